// File: rtl/cpu_state_sequencer_if.sv
// Bus between the multicycle state sequencer and the rest of the core.
// Suffixes (_i/_o) are named from the sequencer's point of view.
interface cpu_state_sequencer_if #(
  parameter int COUNT_W = 32
);
  logic               mem_access_i;
  logic               waitrequest_i;
  logic               halt_req_i;
  logic [1:0]         state_o;
  logic               active_o;
  logic               stall_o;
  logic               fault_o;
  logic               retire_o;
  logic [COUNT_W-1:0] instr_count_o;
  logic [COUNT_W-1:0] cycle_count_o;

  modport master (
    output mem_access_i, waitrequest_i, halt_req_i,
    input  state_o, active_o, stall_o, fault_o, retire_o,
           instr_count_o, cycle_count_o
  );

  modport slave (
    input  mem_access_i, waitrequest_i, halt_req_i,
    output state_o, active_o, stall_o, fault_o, retire_o,
           instr_count_o, cycle_count_o
  );
endinterface

// File: rtl/cpu_state_sequencer.sv
// Multicycle FETCH -> EXEC1 -> EXEC2 sequencer with memory-stall handling,
// halt, retired-instruction / active-cycle counters and a stall watchdog.
module cpu_state_sequencer #(
  parameter int COUNT_W     = 32,
  parameter int STALL_LIMIT = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  cpu_state_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC1  = 2'd1,
    EXEC2  = 2'd2,
    HALTED = 2'd3
  } state_e;

  // The counter only has to reach STALL_LIMIT-1 before the watchdog fires.
  localparam int SC_W = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;
  localparam logic [SC_W-1:0] SC_LAST = SC_W'((STALL_LIMIT > 0) ? STALL_LIMIT - 1 : 0);

  state_e             state_q, state_d;
  logic               fault_q, fault_d;
  logic [COUNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic [COUNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [SC_W-1:0]    stall_cnt_q, stall_cnt_d;

  logic stall, retire, wd_fire, active;

  assign active  = (state_q != HALTED);
  assign stall   = bus.mem_access_i & bus.waitrequest_i & active;
  assign retire  = (state_q == EXEC2) & ~stall;
  assign wd_fire = (STALL_LIMIT != 0) && stall && (stall_cnt_q == SC_LAST);

  always_comb begin
    state_d     = state_q;
    fault_d     = fault_q;
    instr_cnt_d = instr_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    stall_cnt_d = stall_cnt_q;

    if (active) begin
      cycle_cnt_d = cycle_cnt_q + COUNT_W'(1);
      stall_cnt_d = stall ? stall_cnt_q + SC_W'(1) : '0;
      if (retire) instr_cnt_d = instr_cnt_q + COUNT_W'(1);
    end

    // Watchdog overrides whatever the sequence would have done this cycle.
    if (wd_fire) begin
      state_d = HALTED;
      fault_d = 1'b1;
    end else if (!stall) begin
      case (state_q)
        FETCH:   state_d = EXEC1;
        EXEC1:   state_d = EXEC2;
        EXEC2:   state_d = bus.halt_req_i ? HALTED : FETCH;
        HALTED:  state_d = HALTED;
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= FETCH;
      fault_q     <= 1'b0;
      instr_cnt_q <= '0;
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fault_q     <= fault_d;
      instr_cnt_q <= instr_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.state_o       = state_q;
  assign bus.active_o      = active;
  assign bus.stall_o       = stall;
  assign bus.fault_o       = fault_q;
  assign bus.retire_o      = retire;
  assign bus.instr_count_o = instr_cnt_q;
  assign bus.cycle_count_o = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_state_sequencer.sv
// Scoreboard bench for cpu_state_sequencer: directed stimulus pushes expected
// snapshots and retirements; a monitor pops and compares them.
module tb_cpu_state_sequencer;
  localparam int CW = 4;

  typedef struct packed {
    logic [1:0]    state;
    logic          active, stall, fault, retire;
    logic [CW-1:0] instr, cycle;
  } snap_t;

  typedef struct packed {
    logic [CW-1:0] instr, cycle;
  } ret_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic snap_req = 1'b0;
  logic snap_async = 1'b0;
  logic final_chk = 1'b0;

  snap_t snap_q[$];
  string name_q[$];
  ret_t  ret_q[$];
  int    n_chk = 0;
  int    n_pass = 0;
  int    n_ret = 0;

  cpu_state_sequencer_if #(.COUNT_W(CW)) bus ();

  cpu_state_sequencer #(.COUNT_W(CW), .STALL_LIMIT(8)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic string s2str(snap_t s);
    return $sformatf("st=%0d act=%0b stall=%0b fault=%0b ret=%0b instr=%0d cyc=%0d",
                     s.state, s.active, s.stall, s.fault, s.retire, s.instr, s.cycle);
  endfunction

  // Monitor: snapshot compares on request, retire compares on every retire pulse.
  always @(negedge clk or posedge snap_async) begin : monitor
    snap_t act, exp;
    ret_t  ra, re;
    string nm;
    act.state  = bus.state_o;
    act.active = bus.active_o;
    act.stall  = bus.stall_o;
    act.fault  = bus.fault_o;
    act.retire = bus.retire_o;
    act.instr  = bus.instr_count_o;
    act.cycle  = bus.cycle_count_o;
    if (snap_req || snap_async) begin
      n_chk++;
      if (snap_q.size() == 0) begin
        $display("FAIL snap: no expected entry, actual %s", s2str(act));
      end else begin
        exp = snap_q.pop_front();
        nm  = name_q.pop_front();
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %s required %s", nm, s2str(act), s2str(exp));
      end
    end
    if (!snap_async && bus.retire_o === 1'b1) begin
      n_chk++;
      n_ret++;
      ra.instr = bus.instr_count_o;
      ra.cycle = bus.cycle_count_o;
      if (ret_q.size() == 0) begin
        $display("FAIL retire%0d: unexpected retire instr=%0d cyc=%0d", n_ret, ra.instr, ra.cycle);
      end else begin
        re = ret_q.pop_front();
        if (ra === re) n_pass++;
        else $display("FAIL retire%0d: actual instr=%0d cyc=%0d required instr=%0d cyc=%0d",
                      n_ret, ra.instr, ra.cycle, re.instr, re.cycle);
      end
    end
    if (!snap_async && final_chk) begin
      n_chk += 2;
      if (ret_q.size() == 0) n_pass++;
      else $display("FAIL retire_drain: actual %0d pending retires required 0", ret_q.size());
      if (snap_q.size() == 0) n_pass++;
      else $display("FAIL snap_drain: actual %0d pending snapshots required 0", snap_q.size());
    end
  end

  task automatic cyc(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(logic m, logic w, logic h);
    bus.mem_access_i  = m;
    bus.waitrequest_i = w;
    bus.halt_req_i    = h;
  endtask

  function automatic snap_t mk(logic [1:0] st, logic ac, logic sl, logic fl, logic rt,
                               int ic, int cc);
    snap_t s;
    s.state = st; s.active = ac; s.stall = sl; s.fault = fl; s.retire = rt;
    s.instr = CW'(ic); s.cycle = CW'(cc);
    return s;
  endfunction

  task automatic snap(string nm, logic [1:0] st, logic ac, logic sl, logic fl, logic rt,
                      int ic, int cc);
    snap_q.push_back(mk(st, ac, sl, fl, rt, ic, cc));
    name_q.push_back(nm);
    snap_req = 1'b1;
    @(negedge clk);
    #1 snap_req = 1'b0;
  endtask

  task automatic async_snap(string nm, logic [1:0] st, logic ac, logic sl, logic fl,
                            logic rt, int ic, int cc);
    snap_q.push_back(mk(st, ac, sl, fl, rt, ic, cc));
    name_q.push_back(nm);
    snap_async = 1'b1;
    #1 snap_async = 1'b0;
  endtask

  task automatic exp_ret(int ic, int cc);
    ret_t r;
    r.instr = CW'(ic);
    r.cycle = CW'(cc);
    ret_q.push_back(r);
  endtask

  // Reset asserted now, released just after the next rising edge: returns in cycle 1.
  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish within 100000 time units");
    $fatal(1);
  end

  initial begin
    drive(1'b0, 1'b0, 1'b0);
    snap("reset_hold", 2'd0, 1, 0, 0, 0, 0, 0);
    cyc();
    rst_n = 1'b1;

    // Plain sequencing: three unstalled instructions.
    for (int k = 1; k <= 3; k++) exp_ret(k - 1, 3 * k - 1);
    snap("seq_c1", 2'd0, 1, 0, 0, 0, 0, 0);
    cyc(8);
    snap("seq_c9_exec2", 2'd2, 1, 0, 0, 1, 2, 8);
    cyc();
    snap("seq_c10", 2'd0, 1, 0, 0, 0, 3, 9);

    // Four stalled FETCH cycles, then waitrequest alone must not stall.
    do_reset();
    drive(1, 1, 0);
    snap("stall_c1", 2'd0, 1, 1, 0, 0, 0, 0);
    cyc(3);
    snap("stall_c4", 2'd0, 1, 1, 0, 0, 0, 3);
    cyc();
    drive(0, 1, 0);
    snap("wait_no_access", 2'd0, 1, 0, 0, 0, 0, 4);
    cyc();
    exp_ret(0, 6);
    snap("stall_exec1", 2'd1, 1, 0, 0, 0, 0, 5);
    cyc();
    drive(0, 0, 0);
    cyc();
    snap("stall_after_retire", 2'd0, 1, 0, 0, 0, 1, 7);

    // Halt ignored outside EXEC2 and while stalled in EXEC2.
    do_reset();
    drive(0, 0, 1);
    exp_ret(0, 3);
    exp_ret(1, 6);
    cyc();
    cyc();
    drive(1, 1, 1);
    snap("halt_stalled_e2", 2'd2, 1, 1, 0, 0, 0, 2);
    cyc();
    drive(0, 0, 0);
    snap("halt_e2_no_req", 2'd2, 1, 0, 0, 1, 0, 3);
    cyc();
    drive(0, 0, 1);
    cyc(2);
    cyc();
    drive(1, 1, 0);
    snap("halted", 2'd3, 0, 0, 0, 0, 2, 7);
    cyc(2);
    drive(0, 0, 1);
    snap("halted_frozen", 2'd3, 0, 0, 0, 0, 2, 7);

    // Watchdog: 7 stalls, a clearing gap, then 8 stalls in EXEC2 fire it.
    do_reset();
    cyc();
    drive(1, 1, 0);
    cyc(6);
    snap("wd_c8_stall7", 2'd1, 1, 1, 0, 0, 0, 7);
    cyc();
    drive(0, 0, 0);
    snap("wd_c9_clear", 2'd1, 1, 0, 0, 0, 0, 8);
    cyc();
    drive(1, 1, 1);
    snap("wd_c10", 2'd2, 1, 1, 0, 0, 0, 9);
    cyc(6);
    snap("wd_c16", 2'd2, 1, 1, 0, 0, 0, 15);
    cyc();
    snap("wd_c17_last", 2'd2, 1, 1, 0, 0, 0, 0);
    cyc();
    snap("wd_fired", 2'd3, 0, 0, 1, 0, 0, 1);

    // Counter wrap with COUNT_W=4: 16 instructions, 48 cycles.
    do_reset();
    for (int k = 1; k <= 16; k++) exp_ret((k - 1) % 16, (3 * k - 1) % 16);
    cyc(48);
    snap("wrap", 2'd0, 1, 0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of a stalled EXEC1.
    do_reset();
    cyc();
    drive(1, 1, 0);
    snap("ar_stall_e1", 2'd1, 1, 1, 0, 0, 0, 1);
    cyc();
    drive(0, 0, 0);
    rst_n = 1'b0;
    #1;
    async_snap("ar_immediate", 2'd0, 1, 0, 0, 0, 0, 0);
    cyc();
    rst_n = 1'b1;
    exp_ret(0, 2);
    snap("ar_restart", 2'd0, 1, 0, 0, 0, 0, 0);
    cyc(3);
    snap("ar_after_retire", 2'd0, 1, 0, 0, 0, 1, 3);

    final_chk = 1'b1;
    @(negedge clk);
    #1 final_chk = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cpu_state_sequencer.md
Name: cpu_state_sequencer

Overview:
- Multicycle state sequencer for the MIPS CPU core. Sits directly upstream of the control decoder and drives its state input.
- Steps each instruction through FETCH -> EXEC1 -> EXEC2.
- Stalls while the memory bus asserts waitrequest during a cycle that accesses memory.
- Halts the core on a halt request and counts retired instructions and cycles.

Parameters:
- COUNT_W, 32, width of the retired-instruction and cycle counters.
- STALL_LIMIT, 1024, consecutive stalled cycles tolerated before a bus fault halts the core; 0 disables the watchdog.

Ports:
- clk_i  input  1  core clock; all state changes on its rising edge.
- rst_n_i  input  1  asynchronous active-low reset.
- mem_access_i  input  1  current state performs a RAM read or write (ram_rds_o | ram_wen_o from the control decoder).
- waitrequest_i  input  1  memory bus not ready; the access is held.
- halt_req_i  input  1  halt condition (jump target PC == 0); sampled only in EXEC2.
- state_o  output  2  current state: FETCH=0, EXEC1=1, EXEC2=2, HALTED=3.
- active_o  output  1  high in every state except HALTED.
- stall_o  output  1  combinational: mem_access_i & waitrequest_i & (state_o != HALTED).
- fault_o  output  1  sticky; set when the stall watchdog fires.
- retire_o  output  1  one-cycle pulse, high in the cycle that EXEC2 completes.
- instr_count_o  output  COUNT_W  instructions retired since reset.
- cycle_count_o  output  COUNT_W  cycles spent while active_o = 1.

Behaviour:
- Reset (rst_n_i = 0, asynchronous, immediate): state_o=FETCH, active_o=1, fault_o=0, retire_o=0, both counters = 0, internal stall counter = 0. Outputs hold these values while reset is asserted.
- Reset deasserted mid-instruction or mid-stall: restart at FETCH, all counts at 0. Nothing is carried over.
- Transitions occur only when stall_o = 0:
  - FETCH -> EXEC1 -> EXEC2.
  - EXEC2 -> HALTED if halt_req_i = 1, else FETCH.
- When stall_o = 1, the state holds and retire_o = 0.
- Unstalled instruction latency: exactly 3 cycles. Each stalled cycle adds 1.
- waitrequest_i is ignored when mem_access_i = 0; no stall results.
- halt_req_i is ignored outside EXEC2, and ignored in EXEC2 while stalled. It is sampled on the cycle EXEC2 completes.
- retire_o is combinational: (state_o == EXEC2) & ~stall_o.
- instr_count_o increments on every retire_o, including the halting instruction. It wraps modulo 2^COUNT_W.
- cycle_count_o increments every cycle that active_o = 1, stalls included. It wraps modulo 2^COUNT_W.
- Stall watchdog:
  - The internal counter increments each stalled cycle and clears to 0 on any unstalled cycle.
  - If STALL_LIMIT != 0 and a stalled cycle occurs with the counter at STALL_LIMIT-1, then next edge: state_o=HALTED and fault_o=1.
  - The watchdog takes priority over any transition in that cycle.
- HALTED is absorbing until reset:
  - active_o=0, stall_o=0, retire_o=0.
  - Counters freeze; inputs are ignored.
- Illegal state encoding cannot occur in normal operation; if it does, next state is FETCH.
- Simultaneous halt_req_i and watchdog firing in EXEC2: halt to HALTED, fault_o=1.

Test Plan:
- Reset, then 9 cycles with mem_access_i=0 and halt_req_i=0 -> state_o sequence 0,1,2 repeated 3×; retire_o pulses at cycles 3,6,9; instr_count_o=3; cycle_count_o=9.
- mem_access_i=1 in FETCH with waitrequest_i=1 for 4 cycles -> stall_o=1 and state_o=0 for 4 cycles, then EXEC1; the instruction retires 7 cycles after reset.
- halt_req_i=1 held through FETCH and EXEC1, and in EXEC2 of instruction 2 -> instruction 1 still completes to FETCH; HALTED after instruction 2; active_o=0; instr_count_o=2; cycle_count_o frozen at 6.
- STALL_LIMIT=8, waitrequest_i and mem_access_i held at 1 in EXEC1 -> after 8 stalled cycles state_o=3 and fault_o=1; instr_count_o unchanged.
- COUNT_W=4, 16 unstalled instructions -> instr_count_o wraps to 0; cycle_count_o = (48 mod 16) = 0.
- rst_n_i pulsed low asynchronously mid-EXEC1 during a stall -> outputs return to reset values immediately without a clock edge; the next instruction restarts at FETCH.
